stream_ctrl: RTL and testbench
==============================

# stream_ctrl

Packet parser and playback sequencer between the FT245 simple interface and the sample FIFO and modulator. It splits the host byte stream into sample payloads, which go to the FIFO, and commands, which control the modulator. It holds the modulator disabled until the FIFO is primed to a programmable level, and detects underrun. It also returns a one-byte status on the TX simple interface.

## Interface
- DEPTH_WIDTH, 10, FIFO address width; fifo_level is DEPTH_WIDTH+1 bits
- PREFILL_RST, 8'h80, reset value of the prefill register (threshold = reg × 4)
- TIMEOUT_CYCLES, 16'd50000, idle cycles mid-packet before abort
- clk  in  1  system clock
- rst  in  1  synchronous, active-high reset
- rx_data_si  in  8  host byte
- rx_valid_si  in  1  host byte valid
- rx_ready_si  out  1  block accepts byte; transfer when valid & ready
- tx_data_si  out  8  status byte
- tx_valid_si  out  1  status byte valid
- tx_ready_si  in  1  TX side accepts
- fifo_wr_data  out  8  sample to FIFO (= rx_data_si)
- fifo_wr_en  out  1  FIFO write strobe
- fifo_full  in  1  FIFO full
- fifo_empty  in  1  FIFO empty
- fifo_level  in  DEPTH_WIDTH+1  FIFO occupancy
- mod_read  in  1  modulator read strobe toward the FIFO
- mod_enable  out  1  modulator enable
- underrun  out  1  sticky underrun flag
- err  out  1  sticky protocol-error flag

## Operation
- Parser states: IDLE, LEN, PAYLOAD, ADDR, VALUE, REPLY.
- IDLE opcodes:
  - 0x01: go to LEN.
  - 0x02 START: set the start request.
  - 0x03 STOP: set the stop request.
  - 0x04 STATUS: go to REPLY.
  - 0x05: go to ADDR.
  - Any other opcode: set err and stay in IDLE.
- LEN: the byte loads the payload counter; 0 means 256. Then go to PAYLOAD.
- PAYLOAD: each accepted byte asserts fifo_wr_en combinationally in the same cycle and decrements the counter. After the last byte, return to IDLE.
- ADDR/VALUE register writes:
  - addr 0x00 sets prefill (8 bit).
  - addr 0x01 sets ctrl; bit0 = auto_restart, reset 0.
  - Any other addr: set err and discard the value.
- REPLY status byte:
  - tx_data_si = {playing, priming, underrun, err, fifo_full, fifo_empty, 2'b00}, sampled on entry.
  - tx_valid_si is held until tx_ready_si. On that handshake, clear underrun and err, then go to IDLE.
- rx_ready_si = !rst & !(state==PAYLOAD & fifo_full) & state!=REPLY.
- Playback FSM states: STOPPED, PRIMING, PLAYING.
  - STOPPED + START → PRIMING.
  - PRIMING → PLAYING when fifo_level ≥ {prefill,2'b00}. A threshold of 0 passes immediately.
  - PLAYING + (mod_read & fifo_empty) → underrun event. Set underrun; the 8-bit saturating underrun count is internal. Go to PRIMING if auto_restart, else STOPPED.
  - STOP from any state → STOPPED.
  - START while already PRIMING or PLAYING is ignored.
- mod_enable = 1 only in PLAYING (registered).
- Sticky flags: if a set and a clear occur in the same cycle, the set wins.

## Timing
- Reset values:
  - Outputs: mod_enable 0, tx_valid_si 0, tx_data_si 0, fifo_wr_en 0, underrun 0, err 0, rx_ready_si 0 while rst is high.
  - Internal state: parser IDLE, playback STOPPED, prefill PREFILL_RST, ctrl 0.
- Reset mid-packet or mid-reply drops the packet and deasserts tx_valid_si on the next edge.
- START accepted at edge N → PRIMING at N+1. If the level condition holds at N+1, mod_enable=1 at N+2.
- Underrun seen at edge N → mod_enable=0 at N+1.
- STATUS opcode accepted at edge N → tx_valid_si=1 from N+1.
- FIFO write latency is 0 cycles relative to the RX handshake. fifo_wr_en is never asserted when fifo_full=1.
- Timeout:
  - The idle counter runs in LEN, PAYLOAD, ADDR and VALUE only while rx_valid_si=0. It is cleared on every accepted byte and in all other states.
  - On reaching TIMEOUT_CYCLES: set err and go to IDLE.
  - Backpressure caused by fifo_full does not count toward the timeout.

## Configuration
- STREAM_CTRL_TIMEOUT_EN defined: the mid-packet timeout described above is compiled in.
- STREAM_CTRL_TIMEOUT_EN undefined:
  - No counter logic; the parser waits indefinitely for the next byte.
  - TIMEOUT_CYCLES is unused.
  - err is set only by a bad opcode or bad address.

## Test plan
- Prefill and start:
  - Stimulus: write 0x05,0x00,0x01 (threshold 4); send 0x02; send 0x01,0x05 plus 5 samples.
  - Required: fifo_wr_en pulses 5 times with the data matching. mod_enable rises 2 cycles after fifo_level reaches 4.
- Length 0:
  - Stimulus: send 0x01,0x00 plus 256 bytes, then 0x04.
  - Required: exactly 256 FIFO writes; the next byte is parsed as the opcode and the status reply follows.
- Backpressure:
  - Stimulus: hold fifo_full=1 mid-payload for 100 cycles.
  - Required: rx_ready_si=0, no writes; the transfer resumes with no byte lost or duplicated.
- Underrun:
  - Stimulus: while PLAYING, drive mod_read=1 with fifo_empty=1, first with auto_restart=0, then with auto_restart=1.
  - Required, auto_restart=0: mod_enable=0 next cycle; STATUS returns 0x24 (underrun|fifo_empty).
  - Required, auto_restart=1: returns to PRIMING.
  - Required, second STATUS: bit5 clear.
- Errors:
  - Stimulus: send opcode 0x7F; then write 0x05,0x09,0x11; then STATUS.
  - Required: status bit4 set; prefill and ctrl unchanged.
- Timeout (macro defined, TIMEOUT_CYCLES=20):
  - Stimulus: send 0x01,0x03 and one sample, then idle 20 cycles.
  - Required: parser in IDLE, err=1; a subsequent 0x04 returns a status reply.

Source files
------------

// File: rtl/stream_ctrl.sv
// stream_ctrl: FT245 packet parser and playback sequencer feeding the sample FIFO and modulator.
// Define STREAM_CTRL_TIMEOUT_EN to compile in the mid-packet idle timeout.
module stream_ctrl #(
    parameter int          DEPTH_WIDTH    = 10,
    parameter logic [7:0]  PREFILL_RST    = 8'h80,
    parameter logic [15:0] TIMEOUT_CYCLES = 16'd50000
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [7:0]           rx_data_si,
    input  logic                 rx_valid_si,
    output logic                 rx_ready_si,
    output logic [7:0]           tx_data_si,
    output logic                 tx_valid_si,
    input  logic                 tx_ready_si,
    output logic [7:0]           fifo_wr_data,
    output logic                 fifo_wr_en,
    input  logic                 fifo_full,
    input  logic                 fifo_empty,
    input  logic [DEPTH_WIDTH:0] fifo_level,
    input  logic                 mod_read,
    output logic                 mod_enable,
    output logic                 underrun,
    output logic                 err
);

    typedef enum logic [2:0] {P_IDLE, P_LEN, P_PAYLOAD, P_ADDR, P_VALUE, P_REPLY} parse_t;
    typedef enum logic [1:0] {STOPPED, PRIMING, PLAYING} play_t;

    localparam logic [7:0] OP_PKT    = 8'h01;
    localparam logic [7:0] OP_START  = 8'h02;
    localparam logic [7:0] OP_STOP   = 8'h03;
    localparam logic [7:0] OP_STATUS = 8'h04;
    localparam logic [7:0] OP_REG    = 8'h05;

    parse_t ps, ps_next;
    play_t  pb, pb_next;

    logic [8:0]           pay_cnt, pay_cnt_next;
    logic [7:0]           reg_addr;
    logic [7:0]           prefill;
    logic                 auto_restart;
    logic [7:0]           underrun_cnt;
    logic                 acc, tx_done, start_req, stop_req;
    logic                 underrun_evt, err_set, timeout;
    logic [DEPTH_WIDTH:0] thresh;

    assign rx_ready_si  = !rst && !(ps == P_PAYLOAD && fifo_full) && (ps != P_REPLY);
    assign acc          = rx_valid_si && rx_ready_si;
    assign tx_done      = tx_valid_si && tx_ready_si;
    assign fifo_wr_data = rx_data_si;
    assign fifo_wr_en   = acc && (ps == P_PAYLOAD);
    assign start_req    = acc && (ps == P_IDLE) && (rx_data_si == OP_START);
    assign stop_req     = acc && (ps == P_IDLE) && (rx_data_si == OP_STOP);
    assign thresh       = (DEPTH_WIDTH+1)'({prefill, 2'b00});
    assign underrun_evt = (pb == PLAYING) && mod_read && fifo_empty;

`ifdef STREAM_CTRL_TIMEOUT_EN
    // Counts only genuine host silence; a byte stalled by fifo_full keeps rx_valid_si high.
    logic [15:0] idle_cnt;
    logic        counting;

    assign counting = (ps == P_LEN) || (ps == P_PAYLOAD) || (ps == P_ADDR) || (ps == P_VALUE);
    assign timeout  = counting && !rx_valid_si && (idle_cnt == TIMEOUT_CYCLES - 16'd1);

    always_ff @(posedge clk) begin
        if (rst || !counting || acc || timeout)
            idle_cnt <= '0;
        else if (!rx_valid_si)
            idle_cnt <= idle_cnt + 16'd1;
    end
`else
    assign timeout = 1'b0;
`endif

    always_comb begin
        ps_next      = ps;
        pay_cnt_next = pay_cnt;
        err_set      = 1'b0;
        if (timeout) begin
            ps_next = P_IDLE;
            err_set = 1'b1;
        end else begin
            case (ps)
                P_IDLE: begin
                    if (acc) begin
                        case (rx_data_si)
                            OP_PKT:           ps_next = P_LEN;
                            OP_START, OP_STOP: ps_next = P_IDLE;
                            OP_STATUS:        ps_next = P_REPLY;
                            OP_REG:           ps_next = P_ADDR;
                            default:          err_set = 1'b1;
                        endcase
                    end
                end
                P_LEN: begin
                    if (acc) begin
                        pay_cnt_next = (rx_data_si == 8'h00) ? 9'd256 : {1'b0, rx_data_si};
                        ps_next      = P_PAYLOAD;
                    end
                end
                P_PAYLOAD: begin
                    if (acc) begin
                        pay_cnt_next = pay_cnt - 9'd1;
                        if (pay_cnt == 9'd1)
                            ps_next = P_IDLE;
                    end
                end
                P_ADDR: begin
                    if (acc)
                        ps_next = P_VALUE;
                end
                P_VALUE: begin
                    if (acc) begin
                        ps_next = P_IDLE;
                        if (reg_addr > 8'h01)
                            err_set = 1'b1;
                    end
                end
                P_REPLY: begin
                    if (tx_done)
                        ps_next = P_IDLE;
                end
                default: ps_next = P_IDLE;
            endcase
        end
    end

    // Status snapshot is taken on the edge that enters REPLY; sticky flags favour set over clear.
    always_ff @(posedge clk) begin
        if (rst) begin
            ps           <= P_IDLE;
            pay_cnt      <= '0;
            reg_addr     <= '0;
            prefill      <= PREFILL_RST;
            auto_restart <= 1'b0;
            tx_valid_si  <= 1'b0;
            tx_data_si   <= '0;
            err          <= 1'b0;
        end else begin
            ps      <= ps_next;
            pay_cnt <= pay_cnt_next;
            if (acc && ps == P_ADDR)
                reg_addr <= rx_data_si;
            if (acc && ps == P_VALUE) begin
                if (reg_addr == 8'h00)
                    prefill <= rx_data_si;
                else if (reg_addr == 8'h01)
                    auto_restart <= rx_data_si[0];
            end
            if (ps != P_REPLY && ps_next == P_REPLY) begin
                tx_valid_si <= 1'b1;
                tx_data_si  <= {pb == PLAYING, pb == PRIMING, underrun, err,
                                fifo_full, fifo_empty, 2'b00};
            end else if (tx_done) begin
                tx_valid_si <= 1'b0;
            end
            if (err_set)
                err <= 1'b1;
            else if (tx_done)
                err <= 1'b0;
        end
    end

    always_comb begin
        pb_next = pb;
        if (stop_req) begin
            pb_next = STOPPED;
        end else begin
            case (pb)
                STOPPED: if (start_req) pb_next = PRIMING;
                PRIMING: if (fifo_level >= thresh) pb_next = PLAYING;
                PLAYING: if (underrun_evt) pb_next = auto_restart ? PRIMING : STOPPED;
                default: pb_next = STOPPED;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            pb           <= STOPPED;
            mod_enable   <= 1'b0;
            underrun     <= 1'b0;
            underrun_cnt <= '0;
        end else begin
            pb         <= pb_next;
            mod_enable <= (pb_next == PLAYING);
            if (underrun_evt) begin
                underrun <= 1'b1;
                if (underrun_cnt != 8'hFF)
                    underrun_cnt <= underrun_cnt + 8'd1;
            end else if (tx_done) begin
                underrun <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_stream_ctrl.sv
// Scoreboard bench for stream_ctrl: random payloads and handshakes against a packet-level model.
module tb_stream_ctrl;

`ifdef STREAM_CTRL_TIMEOUT_EN
    localparam logic [15:0] TO = 16'd20;
`else
    localparam logic [15:0] TO = 16'd50000;
`endif
    localparam int PB_STOP = 0, PB_PRIME = 1, PB_PLAY = 2;

    logic        clk = 0, rst = 1;
    logic [7:0]  rx_data = 0;
    logic        rx_valid = 0, rx_ready;
    logic [7:0]  tx_data;
    logic        tx_valid, tx_ready, tx_off = 0;
    logic [7:0]  fifo_wr_data;
    logic        fifo_wr_en, fifo_full_f = 0, fifo_empty;
    logic [10:0] fifo_level;
    logic        mod_read = 0, mod_enable, underrun, err;

    stream_ctrl #(.DEPTH_WIDTH(10), .PREFILL_RST(8'h80), .TIMEOUT_CYCLES(TO)) dut (
        .clk(clk), .rst(rst),
        .rx_data_si(rx_data), .rx_valid_si(rx_valid), .rx_ready_si(rx_ready),
        .tx_data_si(tx_data), .tx_valid_si(tx_valid), .tx_ready_si(tx_ready),
        .fifo_wr_data(fifo_wr_data), .fifo_wr_en(fifo_wr_en),
        .fifo_full(fifo_full_f), .fifo_empty(fifo_empty), .fifo_level(fifo_level),
        .mod_read(mod_read), .mod_enable(mod_enable), .underrun(underrun), .err(err)
    );

    always #5 clk = ~clk;

    // Bench-side FIFO occupancy
    always @(posedge clk)
        if (rst) fifo_level <= '0;
        else     fifo_level <= fifo_level + 11'(fifo_wr_en) - 11'(mod_read && fifo_level != 0);
    assign fifo_empty = (fifo_level == 0);

    int n_chk = 0, n_fail = 0;
    logic [7:0] exp_wr[$];
    logic [7:0] exp_tx[$];
    int  m_pb = PB_STOP;
    logic [7:0] m_prefill = 8'h80;
    logic m_auto = 0, m_err = 0, m_under = 0;

    int cyc = 0, n_wr = 0, trig_wr = -1, trig_cyc = -1, men_cyc = -1;
    bit men_seen = 0, prev_hold = 0;
    logic [7:0] prev_data = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] expv);
        n_chk++;
        if (act !== expv) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, expv, cyc);
        end
    endtask

    initial begin
        tx_ready = 0;
        forever begin
            @(posedge clk); #1;
            tx_ready = tx_off ? 1'b0 : ($urandom_range(0, 2) != 0);
        end
    end

    always @(negedge clk) begin
        cyc++;
        if (rst) begin
            prev_hold = 0;
        end else begin
            if (prev_hold) chk("tx_hold", {23'd0, tx_valid, tx_data}, {23'd0, 1'b1, prev_data});
            if (fifo_wr_en) begin
                n_wr++;
                if (n_wr == trig_wr) trig_cyc = cyc;
                chk("wr_while_full", fifo_full_f, 0);
                chk("wr_expected", exp_wr.size() != 0, 1);
                if (exp_wr.size() != 0) chk("wr_data", fifo_wr_data, exp_wr.pop_front());
            end
            if (tx_valid && tx_ready) begin
                chk("tx_expected", exp_tx.size() != 0, 1);
                if (exp_tx.size() != 0) chk("status", tx_data, exp_tx.pop_front());
            end
            if (mod_enable && !men_seen) begin men_seen = 1; men_cyc = cyc; end
            prev_hold = tx_valid && !tx_ready;
            prev_data = tx_data;
        end
    end

    task automatic step(input int n);
        repeat (n) begin @(posedge clk); #1; end
    endtask

    task automatic send_byte(input logic [7:0] b);
        int n = 0;
        logic rdy = 0;
        rx_valid = 0;
        step($urandom_range(0, 2));
        rx_data = b; rx_valid = 1;
        do begin
            @(negedge clk); rdy = rx_ready;
            @(posedge clk); #1; n++;
        end while (!rdy && n < 400);
        chk("rx_handshake", rdy, 1);
        rx_valid = 0;
    endtask

    task automatic send_pkt(input int n);
        logic [7:0] b;
        send_byte(8'h01);
        send_byte(8'(n));
        for (int i = 0; i < n; i++) begin
            b = 8'($urandom);
            exp_wr.push_back(b);
            send_byte(b);
        end
    endtask

    function automatic void model_settle();
        if (m_pb == PB_PRIME && int'(fifo_level) >= 4 * int'(m_prefill)) m_pb = PB_PLAY;
    endfunction

    task automatic reg_write(input logic [7:0] a, input logic [7:0] v);
        send_byte(8'h05); send_byte(a); send_byte(v);
        if (a == 8'h00)      m_prefill = v;
        else if (a == 8'h01) m_auto = v[0];
        else                 m_err = 1;
    endtask

    task automatic send_start();
        send_byte(8'h02);
        if (m_pb == PB_STOP) m_pb = PB_PRIME;
    endtask

    task automatic send_stop();
        send_byte(8'h03);
        m_pb = PB_STOP;
    endtask

    task automatic send_status();
        int n = 0;
        model_settle();
        exp_tx.push_back({m_pb == PB_PLAY, m_pb == PB_PRIME, m_under, m_err,
                          fifo_full_f, fifo_level == 0, 2'b00});
        send_byte(8'h04);
        while (exp_tx.size() != 0 && n < 200) begin step(1); n++; end
        chk("reply_seen", exp_tx.size(), 0);
        exp_tx.delete();
        m_under = 0; m_err = 0;
    endtask

    task automatic check_play();
        step(4);
        model_settle();
        chk("mod_enable", mod_enable, m_pb == PB_PLAY);
    endtask

    task automatic drain();
        int n = 0;
        model_settle();
        mod_read = 1;
        while (n < 600) begin
            @(negedge clk);
            if (fifo_empty) break;
            @(posedge clk); #1; n++;
        end
        chk("drain_empty", fifo_empty, 1);
        chk("enable_before_underrun", mod_enable, m_pb == PB_PLAY);
        @(posedge clk); #1;
        if (m_pb == PB_PLAY) begin m_under = 1; m_pb = m_auto ? PB_PRIME : PB_STOP; end
        mod_read = 0;
        chk("enable_after_read", mod_enable, m_pb == PB_PLAY);
        chk("underrun_flag", underrun, m_under);
    endtask

    initial begin
        #900000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

    initial begin
        int n, base, bad;
        logic [7:0] b;

        step(3);
        chk("rst_rx_ready", rx_ready, 0);
        chk("rst_mod_enable", mod_enable, 0);
        chk("rst_tx_valid", tx_valid, 0);
        chk("rst_tx_data", tx_data, 0);
        chk("rst_fifo_wr_en", fifo_wr_en, 0);
        chk("rst_underrun", underrun, 0);
        chk("rst_err", err, 0);
        rst = 0;
        step(1);
        chk("idle_rx_ready", rx_ready, 1);

        // prefill threshold 4, start, then 5 samples
        reg_write(8'h00, 8'h01);
        send_start();
        check_play();
        men_seen = 0; trig_wr = n_wr + 4;
        send_pkt(5);
        n = 0;
        while (!men_seen && n < 100) begin step(1); n++; end
        chk("enable_rise_seen", men_seen, 1);
        chk("enable_latency", men_cyc - trig_cyc, 2);
        check_play();
        send_status();

        // underrun, no auto restart
        drain();
        send_status();
        chk("underrun_cleared", underrun, 0);

        // underrun with auto restart
        reg_write(8'h01, 8'h01);
        send_start();
        send_pkt(4);
        check_play();
        drain();
        send_status();
        send_status();
        check_play();
        send_stop();
        send_status();

        // protocol errors leave prefill and ctrl untouched
        send_byte(8'h7F); m_err = 1;
        reg_write(8'h09, 8'h11);
        send_status();
        send_start();
        send_pkt(3);
        check_play();
        send_pkt(1);
        check_play();
        drain();
        send_stop();
        send_status();

        // length byte 0 means 256
        base = n_wr;
        send_pkt(256);
        step(2);
        chk("len0_writes", n_wr - base, 256);
        send_status();
        drain();

        // backpressure mid-payload
        send_byte(8'h01); send_byte(8'h08);
        for (int i = 0; i < 3; i++) begin b = 8'($urandom); exp_wr.push_back(b); send_byte(b); end
        b = 8'($urandom); exp_wr.push_back(b);
        fifo_full_f = 1; rx_data = b; rx_valid = 1; bad = 0;
        repeat (100) begin
            @(negedge clk); if (rx_ready || fifo_wr_en) bad++;
            @(posedge clk); #1;
        end
        chk("bp_stall", bad, 0);
        fifo_full_f = 0;
        send_byte(b);
        for (int i = 0; i < 4; i++) begin b = 8'($urandom); exp_wr.push_back(b); send_byte(b); end
        step(2);
        chk("bp_all_written", exp_wr.size(), 0);
        drain();

        // threshold 0 passes immediately
        reg_write(8'h00, 8'h00);
        send_start();
        check_play();
        send_stop();
        check_play();

        // host goes silent mid-packet
        send_byte(8'h01); send_byte(8'h03);
        b = 8'($urandom); exp_wr.push_back(b); send_byte(b);
        step(int'(TO < 16'd20 ? TO : 16'd20));
`ifdef STREAM_CTRL_TIMEOUT_EN
        m_err = 1;
        chk("timeout_err", err, 1);
`else
        chk("no_timeout_err", err, 0);
        for (int i = 0; i < 2; i++) begin b = 8'($urandom); exp_wr.push_back(b); send_byte(b); end
`endif
        send_status();
        drain();

        // reset while a reply is pending
        tx_off = 1;
        send_byte(8'h04);
        step(3);
        chk("reply_pending", tx_valid, 1);
        rst = 1;
        step(1);
        chk("rst_drops_tx_valid", tx_valid, 0);
        chk("rst_drops_tx_data", tx_data, 0);
        chk("rst_rx_ready_low", rx_ready, 0);
        rst = 0; tx_off = 0;
        m_pb = PB_STOP; m_prefill = 8'h80; m_auto = 0; m_err = 0; m_under = 0;
        step(1);
        send_status();
        send_start();
        send_pkt(4);
        check_play();
        send_stop();
        check_play();

        step(5);
        chk("wr_queue_drained", exp_wr.size(), 0);
        chk("tx_queue_drained", exp_tx.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
